// File: rtl/reg_ctx_engine.sv
// Register-file context save/restore sequencer driving the accumulator register file and data memory.
// Optional macro CTX_ACC_PRESERVE_EN keeps the accumulator intact across a RESTORE.
module reg_ctx_engine #(
  parameter int reg_width   = 8,
  parameter int reg_pointer = 4,
  parameter int num_reg     = 16,
  parameter int addr_width  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [addr_width-1:0]  base_addr,
  output logic                   busy,
  output logic                   done,
  output logic [reg_pointer-1:0] reg_addr,
  output logic                   reg_read,
  output logic                   reg_write,
  output logic                   acc_write,
  output logic                   memToReg,
  output logic [reg_width-1:0]   value_in,
  input  logic [reg_width-1:0]   reg_out,
  input  logic [reg_width-1:0]   acc_out,
  output logic [addr_width-1:0]  mem_addr,
  output logic                   mem_write,
  output logic [reg_width-1:0]   mem_wdata,
  input  logic [reg_width-1:0]   mem_rdata
);

`ifdef CTX_ACC_PRESERVE_EN
  typedef enum logic [2:0] {IDLE, SAVE, RLOAD, RWRITE, ACCRST, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SAVE, RLOAD, RWRITE, DONE} state_t;
`endif

  localparam logic [reg_pointer-1:0] LAST = reg_pointer'(num_reg - 1);

  state_t                  state, state_n;
  logic [reg_pointer-1:0]  idx, idx_n;
  logic [addr_width-1:0]   base_q;
  logic [addr_width-1:0]   mem_ptr;

  // Address wraps modulo 2**addr_width by truncation.
  assign mem_ptr = base_q + addr_width'(idx);

`ifdef CTX_ACC_PRESERVE_EN
  logic [reg_width-1:0] shadow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow <= '0;
    else if (state == IDLE && start) shadow <= acc_out;
  end
`else
  // The accumulator is only consumed when it must be preserved.
  logic unused_acc;
  assign unused_acc = ^acc_out;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      base_q <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == IDLE && start) base_q <= base_addr;
    end
  end

  // Moore decode: strobes depend only on state and index.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    busy      = 1'b0;
    done      = 1'b0;
    reg_addr  = '0;
    reg_read  = 1'b0;
    reg_write = 1'b0;
    acc_write = 1'b0;
    memToReg  = 1'b0;
    value_in  = '0;
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (start) begin
          idx_n   = '0;
          state_n = mode ? RLOAD : SAVE;
        end
      end
      SAVE: begin
        busy      = 1'b1;
        reg_addr  = idx;
        reg_read  = 1'b1;
        mem_addr  = mem_ptr;
        mem_wdata = reg_out;
        mem_write = 1'b1;
        if (idx == LAST) state_n = DONE;
        else             idx_n   = idx + reg_pointer'(1);
      end
      RLOAD: begin
        busy      = 1'b1;
        mem_addr  = mem_ptr;
        value_in  = mem_rdata;
        acc_write = 1'b1;
        memToReg  = 1'b1;
        state_n   = RWRITE;
      end
      RWRITE: begin
        busy      = 1'b1;
        reg_addr  = idx;
        reg_write = 1'b1;
        if (idx == LAST) begin
`ifdef CTX_ACC_PRESERVE_EN
          state_n = ACCRST;
`else
          state_n = DONE;
`endif
        end else begin
          idx_n   = idx + reg_pointer'(1);
          state_n = RLOAD;
        end
      end
`ifdef CTX_ACC_PRESERVE_EN
      ACCRST: begin
        busy      = 1'b1;
        value_in  = shadow;
        acc_write = 1'b1;
        state_n   = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Directed bench for reg_ctx_engine with behavioural register-file/accumulator and memory models.
module tb_reg_ctx_engine;
  localparam int NR        = 16;
  localparam int SAVE_DONE = NR + 1;
`ifdef CTX_ACC_PRESERVE_EN
  localparam int RST_DONE  = 2*NR + 2;
  localparam int ACC_EXTRA = 1;
`else
  localparam int RST_DONE  = 2*NR + 1;
  localparam int ACC_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic       busy, done, reg_read, reg_write, acc_write, memToReg, mem_write;
  logic [3:0] reg_addr;
  logic [7:0] value_in, reg_out, acc_out, mem_addr, mem_wdata, mem_rdata;

  // Environment: register file, accumulator, data memory
  logic [7:0] regs[16];
  logic [7:0] mem[256];
  logic [7:0] acc;
  logic [7:0] pl_regs[16];
  logic [7:0] pl_mem[256];
  logic [7:0] pl_acc;
  logic       do_pl = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_ctx_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
    .busy(busy), .done(done), .reg_addr(reg_addr), .reg_read(reg_read),
    .reg_write(reg_write), .acc_write(acc_write), .memToReg(memToReg),
    .value_in(value_in), .reg_out(reg_out), .acc_out(acc_out),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign reg_out   = regs[reg_addr];
  assign mem_rdata = mem[mem_addr];
  assign acc_out   = acc;

  always @(posedge clk) begin
    if (do_pl) begin
      regs <= pl_regs;
      mem  <= pl_mem;
      acc  <= pl_acc;
    end else begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (reg_write) regs[reg_addr] <= acc;
      else if (acc_write) acc <= value_in;
    end
  end

  typedef struct {
    logic       mode;
    logic [7:0] base;
    int         pat;
    int         inject;
  } op_t;

  op_t ops[5];

  // run_op results
  int r_first_done, r_n_done, r_n_busy, r_busy_after;
  int r_mw, r_aw, r_rw, r_excl, r_addr_err, r_first_strobe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic commit();
    @(negedge clk);
    do_pl = 1'b1;
    @(negedge clk);
    do_pl = 1'b0;
  endtask

  // pat 0: regs = A0+i, memory cleared; pat 1: regs cleared, mem[a] = a^5A
  task automatic prep(input int pat, input logic [7:0] acc_val);
    logic [7:0] a;
    for (int i = 0; i < 16; i++) pl_regs[i] = (pat == 0) ? 8'hA0 + 8'(i) : 8'h00;
    for (int j = 0; j < 256; j++) begin
      a = 8'(j);
      pl_mem[j] = (pat == 0) ? 8'h00 : (a ^ 8'h5A);
    end
    pl_acc = acc_val;
    commit();
  endtask

  task automatic run_op(input logic m, input logic [7:0] b, input int inject, input int bound);
    int kw, kl, kr;
    logic [7:0] ea;
    kw = 0; kl = 0; kr = 0;
    r_first_done = 0; r_n_done = 0; r_n_busy = 0; r_busy_after = 1;
    r_mw = 0; r_aw = 0; r_rw = 0; r_excl = 0; r_addr_err = 0; r_first_strobe = 0;
    @(negedge clk);
    start = 1'b1; mode = m; base_addr = b;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= bound; cyc++) begin
      start = (inject != 0 && cyc == inject);
      if (busy) r_n_busy++;
      if (done) begin
        r_n_done++;
        if (r_first_done == 0) r_first_done = cyc;
      end
      if (r_first_done != 0 && cyc == r_first_done + 1) r_busy_after = int'(busy);
      if ((int'(mem_write) + int'(acc_write) + int'(reg_write)) > 1) r_excl++;
      if ((mem_write || acc_write || reg_write) && r_first_strobe == 0) r_first_strobe = cyc;
      if (reg_read != mem_write) r_addr_err++;
      if (memToReg && !acc_write) r_addr_err++;
      if (mem_write) begin
        r_mw++;
        ea = b + 8'(kw);
        if (mem_addr !== ea || reg_addr !== 4'(kw)) r_addr_err++;
        kw++;
      end
      if (acc_write) begin
        r_aw++;
        if (memToReg) begin
          ea = b + 8'(kl);
          if (mem_addr !== ea) r_addr_err++;
          kl++;
        end
      end
      if (reg_write) begin
        r_rw++;
        if (reg_addr !== 4'(kr)) r_addr_err++;
        kr++;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] a, orig[16];
    int bad, exp_done;

    ops[0] = '{1'b0, 8'h40, 0, 0};
    ops[1] = '{1'b1, 8'hF8, 1, 0};
    ops[2] = '{1'b0, 8'h40, 0, 5};
    ops[3] = '{1'b0, 8'hFA, 0, 0};
    ops[4] = '{1'b1, 8'h00, 1, 3};

    // Reset state
    prep(0, 8'h00);
    @(negedge clk);
    check("rst_ctrl", {busy, done, reg_read, reg_write, acc_write, memToReg, mem_write}, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_value_in", value_in, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      prep(ops[t].pat, 8'h00);
      exp_done = ops[t].mode ? RST_DONE : SAVE_DONE;
      run_op(ops[t].mode, ops[t].base, ops[t].inject, exp_done + 3);
      check($sformatf("op%0d_done_cycle", t), r_first_done, exp_done);
      check($sformatf("op%0d_done_pulses", t), r_n_done, 1);
      check($sformatf("op%0d_busy_cycles", t), r_n_busy, exp_done - 1);
      check($sformatf("op%0d_busy_after", t), r_busy_after, 0);
      check($sformatf("op%0d_first_strobe", t), r_first_strobe, 1);
      check($sformatf("op%0d_mem_writes", t), r_mw, ops[t].mode ? 0 : NR);
      check($sformatf("op%0d_acc_writes", t), r_aw, ops[t].mode ? NR + ACC_EXTRA : 0);
      check($sformatf("op%0d_reg_writes", t), r_rw, ops[t].mode ? NR : 0);
      check($sformatf("op%0d_exclusive", t), r_excl, 0);
      check($sformatf("op%0d_addr", t), r_addr_err, 0);
      bad = 0;
      if (ops[t].mode == 1'b0) begin
        for (int j = 0; j < 256; j++) begin
          a = 8'(j) - ops[t].base;
          if (a < 8'(NR)) begin
            if (mem[j] !== 8'hA0 + a) bad++;
          end else if (mem[j] !== 8'h00) bad++;
        end
      end else begin
        for (int i = 0; i < NR; i++) begin
          a = ops[t].base + 8'(i);
          if (regs[i] !== (a ^ 8'h5A)) bad++;
        end
      end
      check($sformatf("op%0d_data", t), bad, 0);
    end

    // Reset during RESTORE after three registers have been written
    prep(0, 8'h00);
    for (int j = 0; j < 256; j++) pl_mem[j] = ~8'(j);
    commit();
    @(negedge clk);
    start = 1'b1; mode = 1'b1; base_addr = 8'h20;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 7; cyc++) @(negedge clk);
    check("mid_rload_active", {acc_write, reg_addr}, {1'b1, 4'd0});
    #2 reset = 1'b1;
    #1;
    check("mid_rst_strobes", {busy, done, reg_read, reg_write, acc_write, memToReg, mem_write}, 0);
    check("mid_rst_addr", {reg_addr, mem_addr, value_in}, 0);
    @(negedge clk);
    check("mid_rst_held", {busy, acc_write, reg_write, mem_write}, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < NR; i++) begin
      a = (i < 3) ? ~(8'h20 + 8'(i)) : 8'hA0 + 8'(i);
      if (regs[i] !== a) bad++;
    end
    check("mid_rst_regs", bad, 0);
    prep(0, 8'h00);
    run_op(1'b0, 8'h80, 0, SAVE_DONE + 3);
    check("post_rst_done", r_first_done, SAVE_DONE);
    check("post_rst_writes", r_mw, NR);
    check("post_rst_mem", {mem[8'h80], mem[8'h8F]}, {8'hA0, 8'hAF});

    // Accumulator after RESTORE
    prep(1, 8'h3C);
    run_op(1'b1, 8'h30, 0, RST_DONE + 3);
    check("acc_done_cycle", r_first_done, RST_DONE);
`ifdef CTX_ACC_PRESERVE_EN
    check("acc_final", acc, 8'h3C);
`else
    check("acc_final", acc, 8'h3F ^ 8'h5A);
`endif

    // SAVE then RESTORE round trip at base 0
    for (int i = 0; i < 16; i++) begin
      orig[i] = 8'(i) * 8'h13 + 8'h07;
      pl_regs[i] = orig[i];
    end
    for (int j = 0; j < 256; j++) pl_mem[j] = 8'hFF;
    pl_acc = 8'h00;
    commit();
    run_op(1'b0, 8'h00, 0, SAVE_DONE + 3);
    check("rt_save_done", r_first_done, SAVE_DONE);
    for (int i = 0; i < 16; i++) pl_regs[i] = ~orig[i];
    pl_mem = mem;
    pl_acc = acc;
    commit();
    run_op(1'b1, 8'h00, 0, RST_DONE + 3);
    check("rt_restore_done", r_first_done, RST_DONE);
    bad = 0;
    for (int i = 0; i < 16; i++) if (regs[i] !== orig[i]) bad++;
    check("rt_regs", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
